log_capture_ram: RTL

//  Logging memory downstream of the Tx datapath.
//  - Captures {Q,I} sample pairs into a single-clock dual-port RAM while the micro holds run high.
//  - Raises full once every location has been written.
//  - Serves micro read-back through a registered read port.
//  - Feeds log_data_from_ram / log_out_full_from_ram to the register file.

---
 rtl/log_capture_ram_if.sv | 25 ++
 rtl/log_capture_ram.sv | 99 +++++++++
 2 files changed

// File: rtl/log_capture_ram_if.sv
// Capture/read-back bundle between the Tx log memory and its micro-side register file.
// master drives capture requests, samples and read address; slave returns read data and status.
interface log_capture_ram_if #(
    parameter int NB_DATA = 16,
    parameter int NB_ADDR = 11
);
    logic                   i_run;
    logic                   i_valid;
    logic [NB_DATA-1:0]     i_data_i;
    logic [NB_DATA-1:0]     i_data_q;
    logic [NB_ADDR-1:0]     i_read_addr;
    logic [2*NB_DATA-1:0]   o_read_data;
    logic                   o_full;
    logic                   o_busy;

    modport master (
        output i_run, i_valid, i_data_i, i_data_q, i_read_addr,
        input  o_read_data, o_full, o_busy
    );

    modport slave (
        input  i_run, i_valid, i_data_i, i_data_q, i_read_addr,
        output o_read_data, o_full, o_busy
    );
endinterface

// File: rtl/log_capture_ram.sv
// Captures {q,i} sample pairs into a DEPTH-word log while run is held; 1-cycle registered read port.
// No backpressure: samples are accepted whenever valid during capture and dropped once the log is full.
module log_capture_ram #(
    parameter int NB_DATA = 16,
    parameter int NB_ADDR = 11
) (
    input  logic                 clock,
    input  logic                 i_reset,
    log_capture_ram_if.slave     bus
);
    localparam int DEPTH = 2**NB_ADDR;
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [NB_ADDR-1:0]     wr_addr;
    logic [NB_ADDR-1:0]     wr_addr_nxt;
    logic                   run_d;
    logic                   rise;
    logic                   wr_en;
    logic [2*NB_DATA-1:0]   mem [DEPTH];

    // run_d clears on reset, so a run level held through reset release starts a capture
    assign rise = bus.i_run & ~run_d;

    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr;
        wr_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt   = ST_CAPTURE;
                    wr_addr_nxt = '0;
                end
            end
            ST_CAPTURE: begin
                // dropping run wins over a sample arriving in the same cycle
                if (!bus.i_run) begin
                    state_nxt   = ST_IDLE;
                    wr_addr_nxt = '0;
                end else if (bus.i_valid) begin
                    wr_en       = 1'b1;
                    wr_addr_nxt = wr_addr + NB_ADDR'(1);
                    if (wr_addr == LAST_ADDR) begin
                        state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (!bus.i_run) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                wr_addr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            wr_addr    <= '0;
            run_d      <= 1'b0;
            bus.o_busy <= 1'b0;
            bus.o_full <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_addr    <= wr_addr_nxt;
            run_d      <= bus.i_run;
            bus.o_busy <= (state == ST_CAPTURE);
            bus.o_full <= (state == ST_FULL);
        end
    end

    // Storage is left unreset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= {bus.i_data_q, bus.i_data_i};
        end
    end

    // Read-first: a same-cycle write to the read address returns the previous word.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            bus.o_read_data <= '0;
        end else begin
            bus.o_read_data <= mem[bus.i_read_addr];
        end
    end
endmodule
